// File: rtl/id_ex_register.sv
// ID/EX pipeline register for the 5-stage MIPS datapath.
// Latches the decoded fields and control bits coming out of ID and
// presents them to EX. It also detects load-use hazards and raises
// `stall`, which freezes PC and IF/ID for one cycle while this stage
// loads a bubble. A bubble is an all-zero payload: NOP `sll $0,$0,0`,
// with alu_op 000, funct 000000 and every control bit cleared.
module id_ex_register #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,      // synchronous, active low
    input  logic              halt,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [5:0]        funct_in,
    input  logic [2:0]        alu_op_in,
    input  logic [REG_W-1:0]  rs_in,
    input  logic [REG_W-1:0]  rt_in,
    input  logic [REG_W-1:0]  rd_in,
    input  logic [4:0]        shamt_in,
    input  logic              uses_rs,
    input  logic              uses_rt,
    input  logic [DATA_W-1:0] data1_in,
    input  logic [DATA_W-1:0] data2_in,
    input  logic [DATA_W-1:0] imm_in,
    input  logic [5:0]        ctrl_in,
    output logic              stall,
    output logic              valid_out,
    output logic [5:0]        funct_out,
    output logic [2:0]        alu_op_out,
    output logic [REG_W-1:0]  rs_out,
    output logic [REG_W-1:0]  rt_out,
    output logic [REG_W-1:0]  rd_out,
    output logic [4:0]        shamt_out,
    output logic [DATA_W-1:0] data1_out,
    output logic [DATA_W-1:0] data2_out,
    output logic [DATA_W-1:0] imm_out,
    output logic [5:0]        ctrl_out
);

    // ctrl layout: {reg_write, mem_read, mem_write, mem_to_reg, reg_dst, alu_src}
    localparam int CTRL_MEM_READ = 4;

    typedef struct packed {
        logic              valid;
        logic [5:0]        funct;
        logic [2:0]        alu_op;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        logic [4:0]        shamt;
        logic [DATA_W-1:0] data1;
        logic [DATA_W-1:0] data2;
        logic [DATA_W-1:0] imm;
        logic [5:0]        ctrl;
    } idex_t;

    idex_t stage_q;
    idex_t stage_d;
    idex_t capture;
    logic  load_in_ex;
    logic  hit_rs;
    logic  hit_rt;

    // Load-use detect: the load in EX writes rt, and the instruction in ID
    // reads that register. $0 is excluded because nothing can write it.
    // halt masks the stall, so the freeze during debug comes only from halt.
    always_comb begin
        load_in_ex = stage_q.valid & stage_q.ctrl[CTRL_MEM_READ] & (stage_q.rt != '0);
        hit_rs     = uses_rs & (rs_in == stage_q.rt);
        hit_rt     = uses_rt & (rt_in == stage_q.rt);
        stall      = load_in_ex & (hit_rs | hit_rt) & valid_in & ~halt;
    end

    // Payload taken from ID. A slot marked not-valid still carries its
    // fields, but its control is cleared so it cannot write anything.
    always_comb begin
        capture        = '0;
        capture.valid  = valid_in;
        capture.funct  = funct_in;
        capture.alu_op = alu_op_in;
        capture.rs     = rs_in;
        capture.rt     = rt_in;
        capture.rd     = rd_in;
        capture.shamt  = shamt_in;
        capture.data1  = data1_in;
        capture.data2  = data2_in;
        capture.imm    = imm_in;
        capture.ctrl   = valid_in ? ctrl_in : 6'b0;
    end

    // Next-state priority is hold, then bubble, then capture. A flush and a
    // stall in the same cycle load a single bubble. After that bubble reaches
    // EX, mem_read is clear, so the stall cannot repeat for the same load.
    always_comb begin
        stage_d = stage_q;
        if (halt) begin
            stage_d = stage_q;
        end else if (flush || stall) begin
            stage_d = '0;
        end else begin
            stage_d = capture;
        end
    end

    // Stage register. Reset takes priority over halt.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign valid_out  = stage_q.valid;
    assign funct_out  = stage_q.funct;
    assign alu_op_out = stage_q.alu_op;
    assign rs_out     = stage_q.rs;
    assign rt_out     = stage_q.rt;
    assign rd_out     = stage_q.rd;
    assign shamt_out  = stage_q.shamt;
    assign data1_out  = stage_q.data1;
    assign data2_out  = stage_q.data2;
    assign imm_out    = stage_q.imm;
    assign ctrl_out   = stage_q.ctrl;

endmodule

// File: tb/tb_id_ex_register.sv
// Directed, table-driven bench for id_ex_register.
module tb_id_ex_register;
    localparam int DW = 32;
    localparam int RW = 5;
    localparam int NV = 27;

    localparam int K_CAP  = 0;  // outputs = this cycle's inputs
    localparam int K_NC   = 1;  // fields captured, valid/ctrl zero
    localparam int K_BUB  = 2;  // all zero
    localparam int K_HOLD = 3;  // unchanged

    localparam logic [5:0] ADDU = 6'h21;
    localparam logic [5:0] LWC  = 6'b110101;
    localparam logic [5:0] RC   = 6'b100010;
    localparam logic [5:0] SWC  = 6'b001001;
    localparam logic [5:0] ORIC = 6'b100001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, halt, flush, valid_in, uses_rs, uses_rt;
    logic [5:0] funct_in, ctrl_in;
    logic [2:0] alu_op_in;
    logic [RW-1:0] rs_in, rt_in, rd_in;
    logic [4:0] shamt_in;
    logic [DW-1:0] data1_in, data2_in, imm_in;
    logic stall, valid_out;
    logic [5:0] funct_out, ctrl_out;
    logic [2:0] alu_op_out;
    logic [RW-1:0] rs_out, rt_out, rd_out;
    logic [4:0] shamt_out;
    logic [DW-1:0] data1_out, data2_out, imm_out;

    id_ex_register #(.DATA_W(DW), .REG_W(RW)) dut (
        .clk(clk), .reset(reset), .halt(halt), .flush(flush), .valid_in(valid_in),
        .funct_in(funct_in), .alu_op_in(alu_op_in), .rs_in(rs_in), .rt_in(rt_in),
        .rd_in(rd_in), .shamt_in(shamt_in), .uses_rs(uses_rs), .uses_rt(uses_rt),
        .data1_in(data1_in), .data2_in(data2_in), .imm_in(imm_in), .ctrl_in(ctrl_in),
        .stall(stall), .valid_out(valid_out), .funct_out(funct_out),
        .alu_op_out(alu_op_out), .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out),
        .shamt_out(shamt_out), .data1_out(data1_out), .data2_out(data2_out),
        .imm_out(imm_out), .ctrl_out(ctrl_out)
    );

    typedef struct packed {
        logic          valid;
        logic [5:0]    funct;
        logic [2:0]    aop;
        logic [RW-1:0] rs, rt, rd;
        logic [4:0]    shamt;
        logic [DW-1:0] d1, d2, imm;
        logic [5:0]    ctrl;
    } ov_t;

    typedef struct {
        bit         rst_n, halt, flush, vin;
        logic [5:0] fn;
        logic [2:0] aop;
        logic [4:0] rs, rt, rd;
        bit         urs, urt;
        logic [5:0] ctrl;
        bit         cs, es;
        int         kind;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    vec_t tbl [NV];
    ov_t  act, exp_o, prev_o;

    assign act = {valid_out, funct_out, alu_op_out, rs_out, rt_out, rd_out,
                  shamt_out, data1_out, data2_out, imm_out, ctrl_out};

    function automatic vec_t v(bit r, bit h, bit f, bit vi, logic [5:0] fn, logic [2:0] aop,
                               logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, bit urs, bit urt,
                               logic [5:0] ctrl, bit cs, bit es, int kind);
        vec_t t;
        t.rst_n = r; t.halt = h; t.flush = f; t.vin = vi; t.fn = fn; t.aop = aop;
        t.rs = rs; t.rt = rt; t.rd = rd; t.urs = urs; t.urt = urt; t.ctrl = ctrl;
        t.cs = cs; t.es = es; t.kind = kind;
        return t;
    endfunction

    task automatic check(input string name, input logic [$bits(ov_t)-1:0] a,
                         input logic [$bits(ov_t)-1:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, a, e);
        end
    endtask

    task automatic drive_nohaz_idle();
        halt = 0; flush = 0; valid_in = 0; uses_rs = 0; uses_rt = 0;
        funct_in = 0; alu_op_in = 0; rs_in = 0; rt_in = 0; rd_in = 0;
        shamt_in = 0; data1_in = 0; data2_in = 0; imm_in = 0; ctrl_in = 0;
    endtask

    initial begin
        reset = 0;
        drive_nohaz_idle();

        // reset with junk inputs
        for (int i = 0; i < 2; i++) begin
            tbl[i] = v(0, 1'($urandom), 1'($urandom), 1'($urandom), 6'($urandom), 3'($urandom),
                       5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
                       6'($urandom), (i == 1), 0, K_BUB);
        end
        tbl[2]  = v(1,0,0,1, ADDU,3'b000, 4,5,3, 1,1, RC,  1,0,K_CAP);
        // load-use on rs
        tbl[3]  = v(1,0,0,1, 6'h00,3'b000, 1,2,0, 1,0, LWC, 1,0,K_CAP);
        tbl[4]  = v(1,0,0,1, ADDU,3'b000, 2,4,3, 1,1, RC,  1,1,K_BUB);
        tbl[5]  = v(1,0,0,1, ADDU,3'b000, 2,4,3, 1,1, RC,  1,0,K_CAP);
        // $0 never stalls
        tbl[6]  = v(1,0,0,1, 6'h00,3'b000, 1,0,0, 1,0, LWC, 1,0,K_CAP);
        tbl[7]  = v(1,0,0,1, ADDU,3'b000, 0,4,5, 1,1, RC,  1,0,K_CAP);
        // rt match ignored when uses_rt is clear
        tbl[8]  = v(1,0,0,1, 6'h00,3'b000, 1,7,0, 1,0, LWC, 1,0,K_CAP);
        tbl[9]  = v(1,0,0,1, 6'h2b,3'b000, 3,7,0, 1,0, SWC, 1,0,K_CAP);
        // load-use on rt
        tbl[10] = v(1,0,0,1, 6'h00,3'b000, 1,9,0, 1,0, LWC, 1,0,K_CAP);
        tbl[11] = v(1,0,0,1, ADDU,3'b000, 1,9,4, 1,1, RC,  1,1,K_BUB);
        tbl[12] = v(1,0,0,1, ADDU,3'b000, 1,9,4, 1,1, RC,  1,0,K_CAP);
        // invalid ID slot: no stall, fields kept, ctrl cleared
        tbl[13] = v(1,0,0,1, 6'h00,3'b000, 1,6,0, 1,0, LWC, 1,0,K_CAP);
        tbl[14] = v(1,0,0,0, ADDU,3'b000, 6,4,3, 1,1, RC,  1,0,K_NC);
        // flush of an ori
        tbl[15] = v(1,0,1,1, 6'h25,3'b011, 1,8,0, 1,0, ORIC,1,0,K_BUB);
        // flush together with a hazard: exactly one bubble
        tbl[16] = v(1,0,0,1, 6'h00,3'b000, 1,2,0, 1,0, LWC, 1,0,K_CAP);
        tbl[17] = v(1,0,1,1, ADDU,3'b000, 2,4,3, 1,1, RC,  1,1,K_BUB);
        tbl[18] = v(1,0,0,1, ADDU,3'b000, 2,4,3, 1,1, RC,  1,0,K_CAP);
        // halt for 3 cycles over a pending hazard
        tbl[19] = v(1,0,0,1, 6'h00,3'b000, 1,2,0, 1,0, LWC, 1,0,K_CAP);
        tbl[20] = v(1,1,0,1, ADDU,3'b000, 2,4,3, 1,1, RC,  1,0,K_HOLD);
        tbl[21] = v(1,1,1,1, 6'h23,3'b000, 2,2,6, 1,1, RC,  1,0,K_HOLD);
        tbl[22] = v(1,1,0,0, 6'h24,3'b001, 5,6,7, 0,1, ORIC,1,0,K_HOLD);
        tbl[23] = v(1,0,0,1, 6'h24,3'b000, 3,4,8, 1,1, RC,  1,0,K_CAP);
        // reset in the stall cycle
        tbl[24] = v(1,0,0,1, 6'h00,3'b000, 1,2,0, 1,0, LWC, 1,0,K_CAP);
        tbl[25] = v(0,0,0,1, ADDU,3'b000, 2,4,3, 1,1, RC,  1,1,K_BUB);
        tbl[26] = v(1,0,0,1, ADDU,3'b000, 2,4,3, 1,1, RC,  1,0,K_CAP);

        prev_o = '0;
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            reset = tbl[i].rst_n; halt = tbl[i].halt; flush = tbl[i].flush;
            valid_in = tbl[i].vin; funct_in = tbl[i].fn; alu_op_in = tbl[i].aop;
            rs_in = tbl[i].rs; rt_in = tbl[i].rt; rd_in = tbl[i].rd;
            uses_rs = tbl[i].urs; uses_rt = tbl[i].urt; ctrl_in = tbl[i].ctrl;
            if (!tbl[i].rst_n) begin
                shamt_in = 5'($urandom); data1_in = $urandom; data2_in = $urandom; imm_in = $urandom;
            end else begin
                shamt_in = 5'(i); data1_in = 32'hD100_0000 | 32'(i);
                data2_in = 32'hD200_0000 | 32'(i); imm_in = 32'h0000_F000 | 32'(i);
            end
            #1;
            if (tbl[i].cs) check($sformatf("stall[%0d]", i), {131'b0, stall}, {131'b0, tbl[i].es});
            case (tbl[i].kind)
                K_CAP:  exp_o = {1'b1, funct_in, alu_op_in, rs_in, rt_in, rd_in, shamt_in,
                                 data1_in, data2_in, imm_in, ctrl_in};
                K_NC:   exp_o = {1'b0, funct_in, alu_op_in, rs_in, rt_in, rd_in, shamt_in,
                                 data1_in, data2_in, imm_in, 6'b0};
                K_BUB:  exp_o = '0;
                default: exp_o = prev_o;
            endcase
            @(posedge clk);
            #1;
            check($sformatf("outs[%0d]", i), act, exp_o);
            if (!valid_out) check($sformatf("bubble_ctrl[%0d]", i), {126'b0, ctrl_out}, '0);
            prev_o = exp_o;
        end

        // Hand sequence: halt masks a live stall combinationally, then a
        // released hazard produces a single bubble and a clean retry.
        @(negedge clk);
        reset = 1; drive_nohaz_idle();
        valid_in = 1; rt_in = 5'd11; rs_in = 5'd1; uses_rs = 1; ctrl_in = LWC;
        @(negedge clk);
        valid_in = 1; rs_in = 5'd11; rt_in = 5'd3; uses_rs = 1; uses_rt = 1;
        ctrl_in = RC; funct_in = ADDU;
        #1;
        check("seq_stall_hi", {131'b0, stall}, {131'b0, 1'b1});
        halt = 1;
        #1;
        check("seq_stall_halt", {131'b0, stall}, '0);
        halt = 0;
        #1;
        check("seq_stall_again", {131'b0, stall}, {131'b0, 1'b1});
        @(posedge clk);
        #1;
        check("seq_bubble_valid", {131'b0, valid_out}, '0);
        check("seq_after_bubble_stall", {131'b0, stall}, '0);
        @(posedge clk);
        #1;
        check("seq_retry_rs", {127'b0, rs_out}, {127'b0, 5'd11});
        check("seq_retry_funct", {126'b0, funct_out}, {126'b0, ADDU});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
